// File: rtl/red_pitaya_pid_slew.sv
// Clamp and slew-rate limiter between the PID output and the DAC mux.
// Optional macro PID_SLEW_CNT_EN adds cnt_clr_i / slew_cnt_o (clocks spent slewing).
module red_pitaya_pid_slew #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [14-1:0]    dat_i,
  output logic [14-1:0]    dat_o,
  input  logic [14-1:0]    set_lo_i,
  input  logic [14-1:0]    set_hi_i,
  input  logic [14-1:0]    set_step_i,
  input  logic [DIV_W-1:0] set_div_i,
  input  logic             ena_i,
  input  logic             hold_i,
`ifdef PID_SLEW_CNT_EN
  input  logic             cnt_clr_i,
  output logic [16-1:0]    slew_cnt_o,
`endif
  output logic             lim_o,
  output logic             clamp_o
);

  typedef enum logic [1:0] {
    ST_TRACK = 2'd0,
    ST_SLEW  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [14-1:0]    target_r, target_s;
  logic             clamp_r, clamp_s;
  logic [14-1:0]    dat_r, dat_s;
  logic             lim_r, lim_s;
  logic [DIV_W-1:0] cnt_r, cnt_s;
  logic             tick_s;
  logic [15-1:0]    diff_s;
  logic [15-1:0]    mag_s;

  // Stage 1: clamp window; the hi test wins so an inverted window stays defined
  always_comb begin
    target_s = dat_i;
    clamp_s  = 1'b0;
    if ($signed(dat_i) > $signed(set_hi_i)) begin
      target_s = set_hi_i;
      clamp_s  = 1'b1;
    end else if ($signed(dat_i) < $signed(set_lo_i)) begin
      target_s = set_lo_i;
      clamp_s  = 1'b1;
    end else begin
      target_s = dat_i;
      clamp_s  = 1'b0;
    end
  end

  // Prescaler: a shrunk period wraps to zero without producing a tick
  always_comb begin
    tick_s = 1'b0;
    cnt_s  = cnt_r;
    if (hold_i || !ena_i) begin
      cnt_s = {DIV_W{1'b0}};
    end else if (cnt_r == set_div_i) begin
      tick_s = 1'b1;
      cnt_s  = {DIV_W{1'b0}};
    end else if (cnt_r > set_div_i) begin
      cnt_s = {DIV_W{1'b0}};
    end else begin
      cnt_s = cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Stage 2: step toward the target; a partial step always lands strictly short of it
  always_comb begin
    diff_s = {target_r[13], target_r} - {dat_r[13], dat_r};
    mag_s  = diff_s[14] ? (15'd0 - diff_s) : diff_s;
    dat_s  = dat_r;
    if (hold_i) begin
      dat_s = dat_r;
    end else if (!ena_i) begin
      dat_s = target_r;
    end else if (tick_s) begin
      if ((set_step_i == 14'd0) || (mag_s <= {1'b0, set_step_i})) begin
        dat_s = target_r;
      end else if (diff_s[14]) begin
        dat_s = dat_r - set_step_i;
      end else begin
        dat_s = dat_r + set_step_i;
      end
    end else begin
      dat_s = dat_r;
    end
  end

  // Next state is judged against the values both registers will hold after this edge
  always_comb begin
    lim_s = 1'b0;
    if (hold_i) begin
      state_s = ST_HOLD;
    end else if (ena_i && (dat_s != target_s)) begin
      state_s = ST_SLEW;
    end else begin
      state_s = ST_TRACK;
    end
    if (hold_i) begin
      case (state_r)
        ST_HOLD: lim_s = lim_r;
        ST_SLEW: lim_s = 1'b1;
        default: lim_s = 1'b0;
      endcase
    end else begin
      lim_s = (state_s == ST_SLEW);
    end
  end

  // State, target and output registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_r  <= ST_TRACK;
      target_r <= 14'd0;
      clamp_r  <= 1'b0;
      dat_r    <= 14'd0;
      lim_r    <= 1'b0;
      cnt_r    <= {DIV_W{1'b0}};
    end else begin
      state_r  <= state_s;
      target_r <= target_s;
      clamp_r  <= clamp_s;
      dat_r    <= dat_s;
      lim_r    <= lim_s;
      cnt_r    <= cnt_s;
    end
  end

  assign dat_o   = dat_r;
  assign lim_o   = lim_r;
  assign clamp_o = clamp_r;

`ifdef PID_SLEW_CNT_EN
  logic [16-1:0] slew_cnt_r;

  // Saturating count of clocks spent in SLEW; clear beats increment
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      slew_cnt_r <= 16'd0;
    end else if (cnt_clr_i) begin
      slew_cnt_r <= 16'd0;
    end else if ((state_r == ST_SLEW) && (slew_cnt_r != 16'hFFFF)) begin
      slew_cnt_r <= slew_cnt_r + 16'd1;
    end else begin
      slew_cnt_r <= slew_cnt_r;
    end
  end

  assign slew_cnt_o = slew_cnt_r;
`endif

endmodule

// File: tb/tb_red_pitaya_pid_slew.sv
// Table-driven bench for red_pitaya_pid_slew with a scoreboard queue of expected outputs.
module tb_red_pitaya_pid_slew;

  localparam int L = -8192;
  localparam int H = 8191;

  logic          clk = 1'b0;
  logic          rstn;
  logic [13:0]   dat_i, dat_o, set_lo, set_hi, set_step;
  logic [15:0]   set_div;
  logic          ena, hold, lim_o, clamp_o;
`ifdef PID_SLEW_CNT_EN
  logic          cnt_clr;
  logic [15:0]   slew_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int rstn, dat, ena, hold, step, div, lo, hi;
    int e_dat, e_lim, e_clamp;
  } vec_t;

  typedef struct {
    int idx, d, l, c;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  red_pitaya_pid_slew #(.DIV_W(16)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .dat_i      (dat_i),
    .dat_o      (dat_o),
    .set_lo_i   (set_lo),
    .set_hi_i   (set_hi),
    .set_step_i (set_step),
    .set_div_i  (set_div),
    .ena_i      (ena),
    .hold_i     (hold),
`ifdef PID_SLEW_CNT_EN
    .cnt_clr_i  (cnt_clr),
    .slew_cnt_o (slew_cnt),
`endif
    .lim_o      (lim_o),
    .clamp_o    (clamp_o)
  );

  always #5 clk = ~clk;

  function automatic void add(int r, int d, int e, int h, int st, int dv, int lo, int hi,
                              int ed, int el, int ec);
    vec_t v;
    v.rstn = r; v.dat = d; v.ena = e; v.hold = h; v.step = st; v.div = dv;
    v.lo = lo; v.hi = hi; v.e_dat = ed; v.e_lim = el; v.e_clamp = ec;
    vecs.push_back(v);
  endfunction

  task automatic apply(int r, int d, int e, int h, int st, int dv, int lo, int hi, int clr);
    @(negedge clk);
    rstn = r[0]; dat_i = 14'(d); ena = e[0]; hold = h[0];
    set_step = 14'(st); set_div = 16'(dv); set_lo = 14'(lo); set_hi = 14'(hi);
`ifdef PID_SLEW_CNT_EN
    cnt_clr = clr[0];
`else
    if (clr != 0) $display("note: cnt_clr ignored in this build");
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int idx, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s step %0d got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  initial begin
    // reset, then 0 -> 1000 ramp, step 100 every clock
    add(0, 0, 1, 0, 100, 0, L, H, 0, 0, 0);
    add(0, 0, 1, 0, 100, 0, L, H, 0, 0, 0);
    add(1, 1000, 1, 0, 100, 0, L, H, 0, 1, 0);
    for (int k = 1; k <= 10; k++) add(1, 1000, 1, 0, 100, 0, L, H, 100 * k, (k < 10) ? 1 : 0, 0);
    add(1, 1000, 1, 0, 100, 0, L, H, 1000, 0, 0);
    // bypass back to 0, then div=3 step=50 ramp to -200
    add(1, 0, 0, 0, 100, 0, L, H, 1000, 0, 0);
    add(1, 0, 0, 0, 100, 0, L, H, 0, 0, 0);
    for (int k = 0; k < 16; k++) add(1, -200, 1, 0, 50, 3, L, H, -50 * ((k + 1) / 4), (k != 15) ? 1 : 0, 0);
    add(1, -200, 1, 0, 50, 3, L, H, -200, 0, 0);
    // bypass clamp to +/-500, two clocks of latency
    add(1, 3000, 0, 0, 50, 3, -500, 500, -200, 0, 1);
    add(1, 3000, 0, 0, 50, 3, -500, 500, 500, 0, 1);
    add(1, -3000, 0, 0, 50, 3, -500, 500, 500, 0, 1);
    add(1, -3000, 0, 0, 50, 3, -500, 500, -500, 0, 1);
    // ramp to 1000, hold at 300 for 20 clocks, resume, then reverse to -100
    add(1, 0, 0, 0, 100, 0, L, H, -500, 0, 0);
    add(1, 0, 0, 0, 100, 0, L, H, 0, 0, 0);
    add(1, 1000, 1, 0, 100, 0, L, H, 0, 1, 0);
    for (int k = 1; k <= 3; k++) add(1, 1000, 1, 0, 100, 0, L, H, 100 * k, 1, 0);
    for (int k = 0; k < 20; k++) add(1, 1000, 1, 1, 100, 0, L, H, 300, 1, 0);
    add(1, 1000, 1, 0, 100, 0, L, H, 400, 1, 0);
    add(1, 1000, 1, 0, 100, 0, L, H, 500, 1, 0);
    for (int k = 0; k <= 6; k++) add(1, -100, 1, 0, 100, 0, L, H, 600 - 100 * k, 1, 0);
    add(1, -100, 1, 0, 100, 0, L, H, -100, 0, 0);
    add(1, -100, 1, 0, 100, 0, L, H, -100, 0, 0);
    // step=0 means unlimited; inverted window with hi priority
    add(1, 0, 1, 0, 0, 0, L, H, -100, 1, 0);
    add(1, 8191, 1, 0, 0, 0, L, H, 0, 1, 0);
    add(1, 8191, 1, 0, 0, 0, L, H, 8191, 0, 0);
    add(1, 75, 0, 0, 0, 0, 100, 50, 8191, 0, 1);
    add(1, 200, 0, 0, 0, 0, 100, 50, 50, 0, 1);
    add(1, 20, 0, 0, 0, 0, 100, 50, 50, 0, 1);
    add(1, 20, 0, 0, 0, 0, 100, 50, 100, 0, 1);
    // prescaler cleared by hold, then wrapped by a shrinking period
    add(1, 100, 1, 0, 10, 3, L, H, 100, 0, 0);
    add(1, 200, 1, 0, 10, 3, L, H, 100, 1, 0);
    add(1, 200, 1, 1, 10, 3, L, H, 100, 1, 0);
    add(1, 200, 1, 1, 10, 3, L, H, 100, 1, 0);
    for (int k = 0; k < 3; k++) add(1, 200, 1, 0, 10, 3, L, H, 100, 1, 0);
    add(1, 200, 1, 0, 10, 3, L, H, 110, 1, 0);
    add(1, 200, 1, 0, 10, 3, L, H, 110, 1, 0);
    add(1, 200, 1, 0, 10, 3, L, H, 110, 1, 0);
    add(1, 200, 1, 0, 10, 1, L, H, 110, 1, 0);
    add(1, 200, 1, 0, 10, 1, L, H, 110, 1, 0);
    add(1, 200, 1, 0, 10, 1, L, H, 120, 1, 0);
    // reset mid-slew
    add(0, 200, 1, 0, 10, 1, L, H, 0, 0, 0);
    add(1, 0, 1, 0, 10, 1, L, H, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      e.idx = i; e.d = vecs[i].e_dat; e.l = vecs[i].e_lim; e.c = vecs[i].e_clamp;
      sb.push_back(e);
      apply(vecs[i].rstn, vecs[i].dat, vecs[i].ena, vecs[i].hold, vecs[i].step,
            vecs[i].div, vecs[i].lo, vecs[i].hi, 0);
      e = sb.pop_front();
      chk("dat_o", e.idx, int'($signed(dat_o)), e.d);
      chk("lim_o", e.idx, int'(lim_o), e.l);
      chk("clamp_o", e.idx, int'(clamp_o), e.c);
    end

`ifdef PID_SLEW_CNT_EN
    apply(0, 0, 1, 0, 100, 0, L, H, 0);
    chk("cnt_reset", 0, int'(slew_cnt), 0);
    apply(1, 1000, 1, 0, 100, 0, L, H, 0);
    for (int k = 0; k < 11; k++) apply(1, 1000, 1, 0, 100, 0, L, H, 0);
    chk("cnt_ramp_dat", 1, int'($signed(dat_o)), 1000);
    chk("cnt_ramp", 1, int'(slew_cnt), 10);
    apply(1, 1000, 1, 0, 100, 0, L, H, 1);
    chk("cnt_clear", 2, int'(slew_cnt), 0);
    apply(1, -1000, 1, 0, 100, 0, L, H, 0);
    for (int k = 0; k < 3; k++) apply(1, -1000, 1, 0, 100, 0, L, H, 0);
    chk("cnt_mid_ramp", 3, int'(slew_cnt), 3);
    apply(0, -1000, 1, 0, 100, 0, L, H, 0);
    chk("cnt_rst_dat", 4, int'($signed(dat_o)), 0);
    chk("cnt_rst", 4, int'(slew_cnt), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
